div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage directly upstream of the ALU result mux; its o_div and o_rem drive that mux's divide/remainder inputs.
- Accepts one operation at a time under a start/busy/valid handshake.
- Resolves RISC-V divide-by-zero and signed-overflow cases in one cycle.

Parameters:
- XLEN, 32, operand/result width; the iteration counter is $clog2(XLEN) bits.

Ports:
- i_clk  input  1  core clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; sampled only when o_busy=0.
- i_funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; bit0=1 selects unsigned.
- i_op1  input  XLEN  dividend.
- i_op2  input  XLEN  divisor.
- i_flush  input  1  synchronous abort (pipeline flush).
- o_busy  output  1  operation in progress; high while state != IDLE.
- o_valid  output  1  one-cycle result-ready pulse (registered).
- o_div  output  XLEN  quotient register; holds until the next result write.
- o_rem  output  XLEN  remainder register; holds until the next result write.

Behaviour:
- Reset (async):
  - state=IDLE; o_busy=0, o_valid=0, o_div=0, o_rem=0; counter and working registers cleared.
  - Reset mid-operation aborts with no o_valid.
- States: IDLE, CALC, FIX.
- signed = ~i_funct3[0].
- Captured at start:
  - neg_q = signed & (op1[31]^op2[31]).
  - neg_r = signed & op1[31].
  - Absolute values of both operands when signed.
- IDLE, i_start=1, i_flush=0 at edge T:
  - Divisor == 0: o_div <= all ones; o_rem <= op1; o_valid=1 in cycle T+1; stay IDLE. This applies to both signed and unsigned.
  - Signed, op1=0x80000000 and op2=0xFFFFFFFF: o_div <= 0x80000000; o_rem <= 0; o_valid=1 at T+1; stay IDLE.
  - Otherwise: load working regs, counter <= XLEN-1, state <= CALC.
- CALC: one quotient bit per cycle.
  - Compute trial = {partial_rem, dividend_msb} - divisor, 33-bit.
  - Sign bit of trial = 0: keep trial and shift in 1.
  - Sign bit of trial = 1: restore and shift in 0.
  - Counter decrements each cycle; at counter==0, state <= FIX.
  - CALC occupies cycles T+1..T+32.
- FIX (cycle T+33):
  - o_div <= neg_q ? -q : q; o_rem <= neg_r ? -r : r.
  - o_valid <= 1, state <= IDLE.
  - o_valid is high in cycle T+34, when o_busy is already 0.
- Latency: normal path 34 cycles start-to-valid; special cases 1 cycle. o_busy is high for T+1..T+33.
- o_valid is high for exactly one cycle per accepted op and is 0 otherwise.
- i_start while o_busy=1 is ignored; no queuing.
- i_start in the same cycle that o_valid is high is accepted, since state is IDLE.
- i_flush=1 in any state:
  - Next state IDLE; no o_valid.
  - o_div/o_rem are not updated and keep their prior values.
  - Flush wins over a simultaneous start, including special-case starts.
  - Flush during the FIX cycle suppresses the write and the valid.
- Operand inputs are sampled only at the start edge; changes during CALC have no effect.
- Both o_div and o_rem are written for every funct3; the downstream mux selects between them.

Test Plan:
- DIVU op1=100, op2=7, start at T -> o_busy high T+1..T+33, o_valid at T+34, o_div=14, o_rem=2.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> o_div=0xFFFFFFFD (-3), o_rem=0xFFFFFFFF (-1); REM with op1=7, op2=0xFFFFFFFE -> o_div=0xFFFFFFFD, o_rem=1.
- Divide by zero:
  - REMU op1=0x1234, op2=0 -> o_valid at T+1, o_div=0xFFFFFFFF, o_rem=0x1234, o_busy never high.
  - Repeat with DIV op1=0xFFFFFF00: same one-cycle timing, o_div=0xFFFFFFFF, o_rem=0xFFFFFF00.
- Signed overflow: DIV op1=0x80000000, op2=0xFFFFFFFF -> o_valid at T+1, o_div=0x80000000, o_rem=0. The same operands with DIVU -> 34-cycle path, o_div=0, o_rem=0x80000000.
- Abort and ignored start:
  - Start DIVU 1000/10, then at T+10 pulse i_start with 9/3 -> ignored; result 100/0 at T+34.
  - Then start again and assert i_flush at T+5 -> o_busy 0 from T+6, no o_valid; o_div/o_rem remain 100/0.
- Reset and back-to-back:
  - Assert i_reset at T+20 mid-operation -> all outputs 0 immediately, no o_valid afterward.
  - After release, start DIVU 0xFFFFFFFF/1 in the same cycle another op's o_valid is high -> accepted; o_div=0xFFFFFFFF, o_rem=0.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if: start/busy/valid handshake bundle between the execute stage
// and the iterative divider.
//   i_start   start request, sampled only while o_busy is low
//   i_funct3  100 DIV, 101 DIVU, 110 REM, 111 REMU (bit0 = unsigned)
//   i_op1     dividend
//   i_op2     divisor
//   i_flush   synchronous abort (pipeline flush)
//   o_busy    operation in progress
//   o_valid   one-cycle result-ready pulse
//   o_div     quotient, held until the next result write
//   o_rem     remainder, held until the next result write
// master = issuing pipeline side, slave = divider.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_op1;
    logic [XLEN-1:0] i_op2;
    logic            i_flush;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_div;
    logic [XLEN-1:0] o_rem;

    modport master (
        output i_start, i_funct3, i_op1, i_op2, i_flush,
        input  o_busy, o_valid, o_div, o_rem
    );

    modport slave (
        input  i_start, i_funct3, i_op1, i_op2, i_flush,
        output o_busy, o_valid, o_div, o_rem
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve in
// a single cycle without leaving IDLE.
// Ports:
//   i_clk    core clock, rising edge
//   i_reset  asynchronous, active-high reset
//   bus      div_unit_if.slave handshake/operand/result bundle
// Timing (start accepted at edge T): o_busy high T+1..T+33, o_valid in T+34;
// special cases give o_valid in T+1 with o_busy never raised.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dvd;      // dividend magnitude; quotient bits shift in at the bottom
    logic [XLEN-1:0] dsr;      // divisor magnitude
    logic [XLEN-1:0] prem;     // partial remainder
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] div_r;
    logic [XLEN-1:0] rem_r;
    logic            valid_r;

    // Only bit0 of funct3 distinguishes the operations here.
    logic unused_funct3;
    assign unused_funct3 = ^bus.i_funct3[2:1];

    logic            is_signed;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero, sgn_ovf;
    logic [XLEN:0]   trial;

    assign is_signed = ~bus.i_funct3[0];
    assign abs1      = (is_signed && bus.i_op1[XLEN-1]) ? -bus.i_op1 : bus.i_op1;
    assign abs2      = (is_signed && bus.i_op2[XLEN-1]) ? -bus.i_op2 : bus.i_op2;
    assign div_zero  = (bus.i_op2 == '0);
    assign sgn_ovf   = is_signed && (bus.i_op1 == MIN_NEG) && (bus.i_op2 == '1);
    // prem < dsr always holds, so {prem, next bit} - dsr fits in XLEN+1 bits
    // and the top bit alone tells whether the subtraction succeeded.
    assign trial     = {prem, dvd[XLEN-1]} - {1'b0, dsr};

    logic load, spec_wr, fix_wr;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        spec_wr    = 1'b0;
        fix_wr     = 1'b0;
        if (bus.i_flush) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        if (div_zero || sgn_ovf) begin
                            spec_wr = 1'b1;
                        end else begin
                            load       = 1'b1;
                            state_next = CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt == '0) state_next = FIX;
                end
                FIX: begin
                    fix_wr     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt     <= '0;
            dvd     <= '0;
            dsr     <= '0;
            prem    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div_r   <= '0;
            rem_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= spec_wr | fix_wr;
            if (spec_wr) begin
                if (div_zero) begin
                    div_r <= '1;
                    rem_r <= bus.i_op1;
                end else begin
                    div_r <= MIN_NEG;
                    rem_r <= '0;
                end
            end
            if (load) begin
                dvd   <= abs1;
                dsr   <= abs2;
                prem  <= '0;
                cnt   <= CW'(XLEN - 1);
                neg_q <= is_signed & (bus.i_op1[XLEN-1] ^ bus.i_op2[XLEN-1]);
                neg_r <= is_signed & bus.i_op1[XLEN-1];
            end
            if (state == CALC && !bus.i_flush) begin
                if (!trial[XLEN]) begin
                    prem <= trial[XLEN-1:0];
                    dvd  <= {dvd[XLEN-2:0], 1'b1};
                end else begin
                    prem <= {prem[XLEN-2:0], dvd[XLEN-1]};
                    dvd  <= {dvd[XLEN-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
            end
            if (fix_wr) begin
                div_r <= neg_q ? -dvd : dvd;
                rem_r <= neg_r ? -prem : prem;
            end
        end
    end

    assign bus.o_busy  = (state != IDLE);
    assign bus.o_valid = valid_r;
    assign bus.o_div   = div_r;
    assign bus.o_rem   = rem_r;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, table-driven self-checking bench for div_unit.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ed;
        logic [31:0] er;
        int          lat;
    } vec_t;

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.i_start  = 1'b1;
        bus.i_funct3 = f3;
        bus.i_op1    = a;
        bus.i_op2    = b;
    endtask

    // Called at a negedge with a start already driven. Follows the op from
    // the accepting edge, checking busy/valid every cycle and the result at
    // the valid cycle. poke_k injects an ignored start in that cycle; ch
    // launches the chained op in the valid cycle and returns there.
    task automatic watch(input string name, input int lat, input logic [31:0] ed,
                         input logic [31:0] er, input int poke_k, input bit ch,
                         input logic [2:0] ch_f3, input logic [31:0] ch_a, input logic [31:0] ch_b);
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check({name, " busy"}, {31'b0, bus.o_busy}, {31'b0, k < lat});
            check({name, " valid"}, {31'b0, bus.o_valid}, {31'b0, k == lat});
            if (k == lat) begin
                check({name, " div"}, bus.o_div, ed);
                check({name, " rem"}, bus.o_rem, er);
            end
            if (k == 1) bus.i_start = 1'b0;
            if (poke_k != 0 && k == poke_k) drive_start(F_DIV, 32'd9, 32'd3);
            if (poke_k != 0 && k == poke_k + 1) bus.i_start = 1'b0;
            if (ch && k == lat) begin
                drive_start(ch_f3, ch_a, ch_b);
                return;
            end
        end
    endtask

    // Watches for n cycles that nothing is busy/valid and results are held.
    task automatic quiet(input string name, input int n, input logic [31:0] ed, input logic [31:0] er);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({name, " quiet valid"}, {31'b0, bus.o_valid}, 32'd0);
        end
        check({name, " quiet busy"}, {31'b0, bus.o_busy}, 32'd0);
        check({name, " held div"}, bus.o_div, ed);
        check({name, " held rem"}, bus.o_rem, er);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"divu_100_7",   F_DIVU, 32'd100,      32'd7,        32'd14,       32'd2,        34});
        vecs.push_back('{"div_m7_2",     F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 34});
        vecs.push_back('{"rem_7_m2",     F_REM,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        34});
        vecs.push_back('{"rem_m7_m2",    F_REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34});
        vecs.push_back('{"remu_dz",      F_REMU, 32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,     1});
        vecs.push_back('{"div_dz",       F_DIV,  32'hFFFFFF00, 32'd0,        32'hFFFFFFFF, 32'hFFFFFF00, 1});
        vecs.push_back('{"div_ovf",      F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1});
        vecs.push_back('{"divu_noovf",   F_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 34});
        vecs.push_back('{"div_min_2",    F_DIV,  32'h80000000, 32'd2,        32'hC0000000, 32'd0,        34});
        vecs.push_back('{"remu_big",     F_REMU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 34});

        bus.i_start  = 1'b0;
        bus.i_funct3 = F_DIVU;
        bus.i_op1    = '0;
        bus.i_op2    = '0;
        bus.i_flush  = 1'b0;

        repeat (2) @(negedge clk);
        check("reset busy", {31'b0, bus.o_busy}, 32'd0);
        check("reset valid", {31'b0, bus.o_valid}, 32'd0);
        check("reset div", bus.o_div, 32'd0);
        check("reset rem", bus.o_rem, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive_start(vecs[i].f3, vecs[i].a, vecs[i].b);
            watch(vecs[i].name, vecs[i].lat, vecs[i].ed, vecs[i].er, 0, 1'b0, F_DIVU, '0, '0);
            @(negedge clk);
        end

        // Start while busy is ignored.
        drive_start(F_DIVU, 32'd1000, 32'd10);
        watch("ignored_start", 34, 32'd100, 32'd0, 10, 1'b0, F_DIVU, '0, '0);

        // Flush mid-calculation.
        drive_start(F_DIVU, 32'd500, 32'd7);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.i_start = 1'b0;
            if (k == 5) begin
                check("flush busy before", {31'b0, bus.o_busy}, 32'd1);
                bus.i_flush = 1'b1;
            end
            if (k == 6) begin
                check("flush busy after", {31'b0, bus.o_busy}, 32'd0);
                bus.i_flush = 1'b0;
            end
        end
        quiet("flush_calc", 40, 32'd100, 32'd0);

        // Flush beats a simultaneous special-case start.
        drive_start(F_REMU, 32'h55, 32'd0);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        check("flush_spec valid", {31'b0, bus.o_valid}, 32'd0);
        quiet("flush_spec", 3, 32'd100, 32'd0);

        // Flush in the FIX cycle suppresses write and valid.
        drive_start(F_DIVU, 32'd77, 32'd5);
        @(posedge clk);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) bus.i_start = 1'b0;
            if (k == 33) bus.i_flush = 1'b1;
        end
        @(negedge clk);
        bus.i_flush = 1'b0;
        check("flush_fix valid", {31'b0, bus.o_valid}, 32'd0);
        quiet("flush_fix", 3, 32'd100, 32'd0);

        // Asynchronous reset mid-operation.
        drive_start(F_DIVU, 32'd1000, 32'd3);
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.i_start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("areset busy", {31'b0, bus.o_busy}, 32'd0);
        check("areset div", bus.o_div, 32'd0);
        check("areset rem", bus.o_rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet("after_reset", 40, 32'd0, 32'd0);

        // Back-to-back: new start in the same cycle as the previous valid.
        drive_start(F_DIVU, 32'd100, 32'd7);
        watch("b2b_first", 34, 32'd14, 32'd2, 0, 1'b1, F_DIVU, 32'hFFFFFFFF, 32'd1);
        watch("b2b_second", 34, 32'hFFFFFFFF, 32'd0, 0, 1'b0, F_DIVU, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
